// File: rtl/uart_reg_cmd.sv
// ASCII register-access command interpreter: parses "R<addr>" / "W<addr> <data>" lines
// from the console UART stage, runs one register bus cycle and returns an ASCII reply.
module uart_reg_cmd #(
    parameter int ADDR_W      = 16,
    parameter int DATA_W      = 32,
    parameter int BUS_TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [7:0]        uart_io_rx_d,
    input  logic              uart_io_rx_dv,
    output logic              uart_io_rx_dr,
    input  logic              parity_io_ok,
    input  logic              rx_fifo_nz,
    output logic [7:0]        uart_io_tx_d,
    output logic              uart_io_tx_dv,
    input  logic              uart_io_tx_dr,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_wdata,
    output logic              bus_we,
    output logic              bus_re,
    input  logic [DATA_W-1:0] bus_rdata,
    input  logic              bus_ack
);

    // Handshakes: RX is pull-based, rx_dr high in a cycle lets upstream pop one character,
    // which arrives as a one-cycle rx_dv pulse the next cycle. TX moves a character on
    // any cycle with tx_dv & tx_dr; tx_d is held stable while tx_dv waits for tx_dr.
    localparam int A_DIG = ADDR_W / 4;
    localparam int D_DIG = DATA_W / 4;
    localparam int TO_W  = $clog2(BUS_TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_ADDR, S_DATA, S_SKIP, S_EXEC, S_WAIT_ACK, S_TX_RESP
    } state_t;

    typedef enum logic [2:0] {K_READ, K_OK, K_PAR, K_ERR, K_TOUT} kind_t;

    function automatic logic [4:0] hex_val(input logic [7:0] c);
        logic [7:0] t;
        t = 8'h00;
        if (c >= 8'h30 && c <= 8'h39) t = c - 8'h30;
        else if (c >= 8'h41 && c <= 8'h46) t = c - 8'h37;
        else if (c >= 8'h61 && c <= 8'h66) t = c - 8'h57;
        else return 5'h00;
        return {1'b1, t[3:0]};
    endfunction

    function automatic logic [7:0] hex_chr(input logic [3:0] n);
        return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
    endfunction

    function automatic logic [3:0] resp_last(input kind_t k);
        case (k)
            K_READ:  return 4'(D_DIG);
            K_OK:    return 4'd2;
            default: return 4'd1;
        endcase
    endfunction

    function automatic logic [7:0] resp_char(input kind_t k, input logic [3:0] i,
                                             input logic [3:0] nib);
        if (i == resp_last(k)) return 8'h0D;
        case (k)
            K_READ:  return hex_chr(nib);
            K_OK:    return (i == 4'd0) ? 8'h4F : 8'h4B;
            K_PAR:   return 8'h50;
            K_TOUT:  return 8'h54;
            default: return 8'h3F;
        endcase
    endfunction

    state_t            state_q, state_d;
    kind_t             kind_q, kind_d;
    logic              err_q, err_d;
    logic              is_wr_q, is_wr_d;
    logic              sep_q, sep_d;
    logic              par_bad_q, par_bad_d;
    logic [3:0]        acnt_q, acnt_d;
    logic [3:0]        dcnt_q, dcnt_d;
    logic [3:0]        idx_q, idx_d;
    logic [TO_W-1:0]   tcnt_q, tcnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              rx_dr_q, rx_dr_d;
    logic [7:0]        tx_d_q, tx_d_d;
    logic              tx_dv_q, tx_dv_d;
    logic              re_q, re_d;
    logic              we_q, we_d;

    logic       start_tx;
    kind_t      tx_kind;
    logic [3:0] tx_nib;
    logic [4:0] hv;
    logic       is_space;
    logic       eol;

    assign hv       = hex_val(uart_io_rx_d);
    assign is_space = (uart_io_rx_d == 8'h20);
    assign eol      = rx_dr_q & ~uart_io_rx_dv & ~rx_fifo_nz;

    always_comb begin
        state_d   = state_q;
        kind_d    = kind_q;
        err_d     = err_q;
        is_wr_d   = is_wr_q;
        sep_d     = sep_q;
        par_bad_d = par_bad_q;
        acnt_d    = acnt_q;
        dcnt_d    = dcnt_q;
        idx_d     = idx_q;
        tcnt_d    = tcnt_q;
        addr_d    = addr_q;
        data_d    = data_q;
        rdata_d   = rdata_q;
        tx_d_d    = tx_d_q;
        tx_dv_d   = tx_dv_q;
        re_d      = re_q;
        we_d      = we_q;
        start_tx  = 1'b0;
        tx_kind   = K_ERR;
        tx_nib    = 4'h0;

        case (state_q)
            S_IDLE: begin
                if (uart_io_rx_dv && !is_space) begin
                    if (uart_io_rx_d == 8'h52 || uart_io_rx_d == 8'h72) begin
                        state_d = S_ADDR;
                        is_wr_d = 1'b0;
                    end else if (uart_io_rx_d == 8'h57 || uart_io_rx_d == 8'h77) begin
                        state_d = S_ADDR;
                        is_wr_d = 1'b1;
                    end else begin
                        err_d   = 1'b1;
                        state_d = S_SKIP;
                    end
                end
            end
            S_ADDR: begin
                if (uart_io_rx_dv) begin
                    if (is_space) begin
                        // A read takes no second field: a space just closes the address.
                        if (acnt_q != 4'd0) begin
                            if (is_wr_q) state_d = S_DATA;
                            else         sep_d   = 1'b1;
                        end
                    end else if (!hv[4] || sep_q || acnt_q == 4'(A_DIG)) begin
                        err_d   = 1'b1;
                        state_d = S_SKIP;
                    end else begin
                        addr_d = (addr_q << 4) | ADDR_W'(hv[3:0]);
                        acnt_d = acnt_q + 4'd1;
                    end
                end else if (eol) begin
                    state_d   = S_EXEC;
                    par_bad_d = ~parity_io_ok;
                    if (acnt_q == 4'd0 || is_wr_q) err_d = 1'b1;
                end
            end
            S_DATA: begin
                if (uart_io_rx_dv) begin
                    if (!is_space) begin
                        if (!hv[4] || dcnt_q == 4'(D_DIG)) begin
                            err_d   = 1'b1;
                            state_d = S_SKIP;
                        end else begin
                            data_d = (data_q << 4) | DATA_W'(hv[3:0]);
                            dcnt_d = dcnt_q + 4'd1;
                        end
                    end
                end else if (eol) begin
                    state_d   = S_EXEC;
                    par_bad_d = ~parity_io_ok;
                    if (dcnt_q == 4'd0) err_d = 1'b1;
                end
            end
            S_SKIP: begin
                if (!uart_io_rx_dv && eol) begin
                    state_d   = S_EXEC;
                    par_bad_d = ~parity_io_ok;
                end
            end
            S_EXEC: begin
                if (par_bad_q) begin
                    start_tx = 1'b1;
                    tx_kind  = K_PAR;
                end else if (err_q) begin
                    start_tx = 1'b1;
                    tx_kind  = K_ERR;
                end else begin
                    re_d    = ~is_wr_q;
                    we_d    = is_wr_q;
                    tcnt_d  = '0;
                    state_d = S_WAIT_ACK;
                end
            end
            S_WAIT_ACK: begin
                // Ack is checked first so an ack landing on the last count still wins.
                if (bus_ack) begin
                    re_d     = 1'b0;
                    we_d     = 1'b0;
                    start_tx = 1'b1;
                    tx_kind  = is_wr_q ? K_OK : K_READ;
                    tx_nib   = bus_rdata[DATA_W-1 -: 4];
                    if (!is_wr_q) rdata_d = bus_rdata;
                end else if (tcnt_q == TO_W'(BUS_TIMEOUT - 1)) begin
                    re_d     = 1'b0;
                    we_d     = 1'b0;
                    start_tx = 1'b1;
                    tx_kind  = K_TOUT;
                end else begin
                    tcnt_d = tcnt_q + TO_W'(1);
                end
            end
            S_TX_RESP: begin
                if (tx_dv_q) begin
                    if (uart_io_tx_dr) begin
                        tx_dv_d = 1'b0;
                        if (idx_q == resp_last(kind_q)) begin
                            state_d   = S_IDLE;
                            tx_d_d    = 8'h00;
                            err_d     = 1'b0;
                            is_wr_d   = 1'b0;
                            sep_d     = 1'b0;
                            par_bad_d = 1'b0;
                            acnt_d    = 4'd0;
                            dcnt_d    = 4'd0;
                            idx_d     = 4'd0;
                            tcnt_d    = '0;
                            addr_d    = '0;
                            data_d    = '0;
                            rdata_d   = '0;
                        end else begin
                            idx_d = idx_q + 4'd1;
                            if (kind_q == K_READ) rdata_d = rdata_q << 4;
                        end
                    end
                end else begin
                    tx_dv_d = 1'b1;
                    tx_d_d  = resp_char(kind_q, idx_q, rdata_q[DATA_W-1 -: 4]);
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (start_tx) begin
            kind_d  = tx_kind;
            idx_d   = 4'd0;
            tx_dv_d = 1'b1;
            tx_d_d  = resp_char(tx_kind, 4'd0, tx_nib);
            state_d = S_TX_RESP;
        end

        rx_dr_d = (state_d == S_IDLE) || (state_d == S_ADDR) ||
                  (state_d == S_DATA) || (state_d == S_SKIP);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            kind_q    <= K_ERR;
            err_q     <= 1'b0;
            is_wr_q   <= 1'b0;
            sep_q     <= 1'b0;
            par_bad_q <= 1'b0;
            acnt_q    <= 4'd0;
            dcnt_q    <= 4'd0;
            idx_q     <= 4'd0;
            tcnt_q    <= '0;
            addr_q    <= '0;
            data_q    <= '0;
            rdata_q   <= '0;
            rx_dr_q   <= 1'b0;
            tx_d_q    <= 8'h00;
            tx_dv_q   <= 1'b0;
            re_q      <= 1'b0;
            we_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            kind_q    <= kind_d;
            err_q     <= err_d;
            is_wr_q   <= is_wr_d;
            sep_q     <= sep_d;
            par_bad_q <= par_bad_d;
            acnt_q    <= acnt_d;
            dcnt_q    <= dcnt_d;
            idx_q     <= idx_d;
            tcnt_q    <= tcnt_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            rdata_q   <= rdata_d;
            rx_dr_q   <= rx_dr_d;
            tx_d_q    <= tx_d_d;
            tx_dv_q   <= tx_dv_d;
            re_q      <= re_d;
            we_q      <= we_d;
        end
    end

    assign uart_io_rx_dr = rx_dr_q;
    assign uart_io_tx_d  = tx_d_q;
    assign uart_io_tx_dv = tx_dv_q;
    assign bus_addr      = addr_q;
    assign bus_wdata     = data_q;
    assign bus_re        = re_q;
    assign bus_we        = we_q;

endmodule
